// File: rtl/tile_writer.sv
// tile_writer: bus-master engine that fills, clears and prints tile words into tilemap RAM.
module tile_writer #(
    parameter int MAP_BITS = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [MAP_BITS-1:0] cmd_x,
    input  logic [MAP_BITS-1:0] cmd_y,
    input  logic [MAP_BITS-1:0] cmd_w,
    input  logic [MAP_BITS-1:0] cmd_h,
    input  logic [15:0]         cmd_tile,
    input  logic                char_valid,
    output logic                char_ready,
    input  logic [7:0]          char_data,
    input  logic                char_last,
    output logic                bus_req,
    input  logic                bus_gnt,
    output logic                cs_ram,
    output logic [1:0]          wr,
    output logic [15:0]         address,
    output logic [15:0]         dout,
    output logic                busy,
    output logic                done
);
    localparam logic [1:0] OP_FILL = 2'd0, OP_PRINT = 2'd1, OP_CLEAR = 2'd2, OP_NONE = 2'd3;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [1:0] op;
    logic [15:0] tile;
    logic [MAP_BITS-1:0] x0, x, y, col, row, w_m1, h_m1;
    logic fin, accept, go, clr, last_col, last;
    assign cmd_ready  = state == IDLE && !reset;
    assign accept     = cmd_valid && cmd_ready;
    assign bus_req    = state == RUN;
    assign busy       = state == RUN;
    assign done       = state == DONE;
    assign char_ready = state == RUN && bus_gnt && !fin && op == OP_PRINT;
    assign go         = state == RUN && bus_gnt && !fin && (op != OP_PRINT || char_valid);
    assign clr        = cmd_op == OP_CLEAR;
    assign last_col   = col == w_m1;
    assign last       = op == OP_PRINT ? char_last : last_col && row == h_m1;
    always_comb begin
        state_nx = state;
        if (state == IDLE && accept)
            state_nx = (cmd_op == OP_NONE || (cmd_op == OP_FILL && (cmd_w == '0 || cmd_h == '0))) ? DONE : RUN;
        else if (state == RUN && fin)
            state_nx = DONE;
        else if (state == DONE)
            state_nx = IDLE;
    end
    // fin marks that the final cell is on the bus this cycle, so DONE lands one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cs_ram  <= 1'b0;
            wr      <= 2'b00;
            address <= '0;
            dout    <= '0;
            fin     <= 1'b0;
        end else begin
            state  <= state_nx;
            cs_ram <= go;
            wr     <= go ? 2'b11 : 2'b00;
            if (go) begin
                address <= 16'({y, x});
                dout    <= op == OP_PRINT ? {tile[15:8], char_data} : tile;
            end
            if (accept) begin
                op   <= cmd_op;
                tile <= cmd_tile;
                fin  <= 1'b0;
                col  <= '0;
                row  <= '0;
                x0   <= clr ? '0 : cmd_x;
                x    <= clr ? '0 : cmd_x;
                y    <= clr ? '0 : cmd_y;
                w_m1 <= clr ? '1 : cmd_w - 1'b1;
                h_m1 <= clr ? '1 : cmd_h - 1'b1;
            end else if (go) begin
                fin <= last;
                col <= last_col ? '0 : col + 1'b1;
                x   <= last_col ? x0 : x + 1'b1;
                if (last_col) begin
                    y   <= y + 1'b1;
                    row <= row + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tile_writer.sv
// tb_tile_writer: scoreboard bench for tile_writer fill, wrap, print, grant stall, clear and abort.
module tb_tile_writer;
    logic clk = 0, reset = 1, cmd_valid = 0, char_valid = 0, char_last = 0, bus_gnt = 1;
    logic [1:0] cmd_op = 0;
    logic [6:0] cmd_x = 0, cmd_y = 0, cmd_w = 0, cmd_h = 0;
    logic [15:0] cmd_tile = 0;
    logic [7:0] char_data = 0;
    logic cmd_ready, char_ready, bus_req, cs_ram, busy, done;
    logic [1:0] wr;
    logic [15:0] address, dout;
    int checks = 0, failures = 0, nwr = 0, cyc = 0, last_wr_cyc = -10;
    bit toggle = 0;
    logic [31:0] q[$];
    logic [31:0] exp_w;

    tile_writer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_tile(cmd_tile),
        .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data), .char_last(char_last),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .cs_ram(cs_ram), .wr(wr), .address(address),
        .dout(dout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) bus_gnt = toggle ? ~bus_gnt : 1'b1;

    always @(negedge clk) if (cs_ram) begin
        nwr++;
        last_wr_cyc = cyc;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL write_unexpected addr=%h data=%h", address, dout);
        end else begin
            exp_w = q.pop_front();
            if ({address, dout} !== exp_w || wr !== 2'b11) begin
                failures++;
                $display("FAIL write got addr=%h data=%h wr=%b exp addr=%h data=%h wr=11",
                         address, dout, wr, exp_w[31:16], exp_w[15:0]);
            end
        end
    end

    task automatic do_cmd(input logic [1:0] op, input logic [6:0] x, input logic [6:0] y,
                          input logic [6:0] w, input logic [6:0] h, input logic [15:0] tile);
        @(negedge clk);
        #1;
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_tile = tile; cmd_valid = 1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ready_idle got=%b exp=1", cmd_ready);
        end
        @(posedge clk);
        #1 cmd_valid = 0;
    endtask

    task automatic wait_done(input int max, input bit chk_last, input bit chk_req);
        bit seen = 0;
        int req_low = 0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = done;
            if (!seen && bus_req !== 1'b1) req_low++;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL done_timeout after %0d cycles", max);
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL writes_missing got_left=%0d exp=0", q.size());
        end
        if (chk_last) begin
            checks++;
            if (cyc != last_wr_cyc + 1) begin
                failures++;
                $display("FAIL done_latency got=%0d exp=1", cyc - last_wr_cyc);
            end
        end
        if (chk_req) begin
            checks++;
            if (req_low != 0) begin
                failures++;
                $display("FAIL bus_req_held got_low_cycles=%0d exp=0", req_low);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse got done=%b ready=%b busy=%b exp 0 1 0", done, cmd_ready, busy);
        end
    endtask

    task automatic test_reset;
        reset = 1;
        @(negedge clk);
        #1;
        checks++;
        if ({cmd_ready, bus_req, cs_ram, busy, done, char_ready, wr, address, dout} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b req=%b cs=%b busy=%b done=%b cr=%b wr=%b a=%h d=%h exp all 0",
                     cmd_ready, bus_req, cs_ram, busy, done, char_ready, wr, address, dout);
        end
        reset = 0;
        @(negedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_fill;
        q.push_back({16'h0182, 16'hA55A}); q.push_back({16'h0183, 16'hA55A});
        q.push_back({16'h0184, 16'hA55A}); q.push_back({16'h0202, 16'hA55A});
        q.push_back({16'h0203, 16'hA55A}); q.push_back({16'h0204, 16'hA55A});
        do_cmd(2'd0, 7'd2, 7'd3, 7'd3, 7'd2, 16'hA55A);
        @(negedge clk);
        #1;
        checks++;
        if (cs_ram !== 1'b0 || busy !== 1'b1 || bus_req !== 1'b1) begin
            failures++;
            $display("FAIL fill_cycle1 got cs=%b busy=%b req=%b exp 0 1 1", cs_ram, busy, bus_req);
        end
        @(negedge clk);
        #1;
        checks++;
        if (cs_ram !== 1'b1) begin
            failures++;
            $display("FAIL fill_first_write got cs=%b exp=1", cs_ram);
        end
        wait_done(20, 1, 1);
    endtask

    task automatic test_wrap;
        q.push_back({16'h3FFE, 16'h1357}); q.push_back({16'h3FFF, 16'h1357});
        q.push_back({16'h3F80, 16'h1357}); q.push_back({16'h007E, 16'h1357});
        q.push_back({16'h007F, 16'h1357}); q.push_back({16'h0000, 16'h1357});
        do_cmd(2'd0, 7'd126, 7'd127, 7'd3, 7'd2, 16'h1357);
        wait_done(20, 1, 1);
    endtask

    task automatic test_print;
        logic [7:0] chars [3] = '{8'h41, 8'h42, 8'h43};
        bit acc;
        q.push_back({16'h000A, 16'h3041}); q.push_back({16'h000B, 16'h3042});
        q.push_back({16'h008A, 16'h3043});
        do_cmd(2'd1, 7'd10, 7'd0, 7'd2, 7'd0, 16'h30FF);
        for (int k = 0; k < 3; k++) begin
            char_valid = 0;
            repeat (2) @(negedge clk);
            char_valid = 1; char_data = chars[k]; char_last = (k == 2);
            acc = 0;
            for (int g = 0; g < 20 && !acc; g++) begin
                #1 acc = char_ready;
                @(negedge clk);
            end
            checks++;
            if (!acc) begin
                failures++;
                $display("FAIL print_char_ready char=%0d got=0 exp=1", k);
            end
        end
        char_valid = 0; char_last = 0;
        wait_done(10, 1, 0);
    endtask

    task automatic test_grant_toggle;
        int base;
        base = nwr;
        for (int i = 0; i < 4; i++) q.push_back({16'h0085 + 16'(i), 16'h0F0F});
        toggle = 1;
        do_cmd(2'd0, 7'd5, 7'd1, 7'd4, 7'd1, 16'h0F0F);
        wait_done(30, 1, 1);
        toggle = 0;
        checks++;
        if (nwr - base != 4) begin
            failures++;
            $display("FAIL toggle_count got=%0d exp=4", nwr - base);
        end
    endtask

    task automatic test_zero;
        int base;
        base = nwr;
        do_cmd(2'd0, 7'd9, 7'd9, 7'd0, 7'd5, 16'hFFFF);
        wait_done(5, 0, 0);
        do_cmd(2'd3, 7'd9, 7'd9, 7'd4, 7'd4, 16'hFFFF);
        wait_done(5, 0, 0);
        checks++;
        if (nwr != base) begin
            failures++;
            $display("FAIL zero_fill_writes got=%0d exp=0", nwr - base);
        end
    endtask

    task automatic test_clear;
        for (int yy = 0; yy < 128; yy++)
            for (int xx = 0; xx < 128; xx++)
                q.push_back({16'(yy * 128 + xx), 16'h0000});
        do_cmd(2'd2, 7'd33, 7'd44, 7'd1, 7'd1, 16'h0000);
        wait_done(16500, 1, 1);
    endtask

    task automatic test_reset_mid;
        int base;
        bit hit = 0;
        base = nwr;
        q.push_back({16'h0182, 16'h1234}); q.push_back({16'h0183, 16'h1234});
        q.push_back({16'h0184, 16'h1234});
        do_cmd(2'd0, 7'd2, 7'd3, 7'd3, 7'd2, 16'h1234);
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            #1 hit = (nwr - base == 3);
        end
        reset = 1;
        @(negedge clk);
        #1;
        checks++;
        if ({cmd_ready, bus_req, cs_ram, busy, done, char_ready, wr, address, dout} !== '0) begin
            failures++;
            $display("FAIL abort_outputs got req=%b cs=%b busy=%b done=%b wr=%b a=%h d=%h exp all 0",
                     bus_req, cs_ram, busy, done, wr, address, dout);
        end
        reset = 0;
        hit = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 hit |= done;
        end
        checks++;
        if (hit || nwr - base != 3 || cmd_ready !== 1'b1 || q.size() != 0) begin
            failures++;
            $display("FAIL abort_after got done=%b writes=%0d ready=%b left=%0d exp 0 3 1 0",
                     hit, nwr - base, cmd_ready, q.size());
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_wrap;
        test_print;
        test_grant_toggle;
        test_zero;
        test_clear;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tile_writer.md
# tile_writer

Bus-master engine that writes tile entries into the tilemap video RAM through the same 16-bit `cs_ram`/`wr`/`address`/`din` port the CPU uses, so the tilemap renderer displays the result. It accepts rectangle-fill, full-clear and string-print commands, arbitrates for the RAM port with a request/grant pair, and issues at most one word write per clock. It sits beside the CPU on the tilemap bus and is the writing end of the tilemap RAM.

## Interface
Parameters:
- `MAP_BITS`, 7: log2 of map width and height in cells (128×128); RAM address is `{y, x}`, 2·MAP_BITS bits.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  engine idle; command accepted when `cmd_valid & cmd_ready` on a rising edge.
- `cmd_op`  in  2  0 = FILL, 1 = PRINT, 2 = CLEAR, 3 = reserved (no-op, immediate done).
- `cmd_x`, `cmd_y`  in  7 each  start cell.
- `cmd_w`, `cmd_h`  in  7 each  rectangle size; for PRINT, `cmd_w` is line width.
- `cmd_tile`  in  16  tile word for FILL/CLEAR; for PRINT, bits 15:8 supply the high byte.
- `char_valid`, `char_ready`  in/out  1  PRINT character stream handshake.
- `char_data`  in  8  character code, used as the low tile byte.
- `char_last`  in  1  final character of the string.
- `bus_req`  out  1  request for the tilemap RAM port.
- `bus_gnt`  in  1  port granted for this cycle.
- `cs_ram`  out  1  RAM select.
- `wr`  out  2  byte write enables; always 2'b11 when writing.
- `address`  out  16  word address; bits 15:14 always 0.
- `dout`  out  16  write data.
- `busy`  out  1  high from command acceptance until `done`.
- `done`  out  1  one-cycle pulse at command completion.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- IDLE: `cmd_ready`=1. On acceptance, latch all cmd fields, set x=cmd_x, y=cmd_y, column/row counters to 0, enter RUN (reserved op or FILL with w=0 or h=0 goes directly to DONE).
- RUN: `bus_req`=1. A write occurs in a cycle only when `bus_gnt`=1 and a word is available; then `cs_ram`=1, `wr`=2'b11, `address`={y,x}, `dout`=word. Otherwise `cs_ram`=0, `wr`=0.
- FILL: word = cmd_tile; traverse row-major, w columns × h rows. x advances mod 128; after w columns x reloads cmd_x and y advances mod 128. After w·h writes → DONE.
- CLEAR: FILL with x=y=0, w=h=128 (16384 writes).
- PRINT: `char_ready` = RUN & `bus_gnt`; word = {cmd_tile[15:8], char_data}; a write happens only on `char_valid & char_ready`. x advances; after `cmd_w` chars (w=0 means 128) x reloads cmd_x, y+1 mod 128. No row limit. Write carrying `char_last` → DONE.
- DONE: one cycle; `done`=1, `bus_req`=0, then IDLE.
- Address arithmetic is 7-bit per axis; coordinates wrap silently at 127→0.
- Reset mid-operation aborts immediately; no further writes, no `done`.

## Timing
- Reset values: `cmd_ready`=0 during reset and 1 from the first cycle after; `bus_req`, `cs_ram`, `busy`, `done`, `char_ready`=0; `wr`=0, `address`=0, `dout`=0.
- All bus outputs are registered. Grant in cycle N produces the write strobe in cycle N+1. `bus_req` stays high through the cycle of the last write. Losing the grant mid-rectangle stalls the engine without skipping or repeating cells.
- FILL of w×h with continuous grant: first write 2 cycles after acceptance, last write after w·h write cycles, `done` on the following cycle.
- `busy` rises the cycle after acceptance and falls with `done`. `cmd_valid` is ignored while busy.
- PRINT: character accepted in cycle N is written in cycle N+1; stalls when `char_valid`=0.

## Test plan
- FILL x=2,y=3,w=3,h=2,tile=16'hA55A, continuous grant → 6 writes to 0x0182,0x0183,0x0184,0x0202,0x0203,0x0204, all data A55A, `done` one cycle after the last write.
- FILL x=126,y=127,w=3,h=2 → addresses 0x3FFE,0x3FFF,0x3F80,0x007E,0x007F,0x0000 (wrap on both axes).
- PRINT x=10,y=0,w=2,tile=16'h3000, chars 'A','B','C'(last) with `char_valid` gaps → writes 0x000A=3041, 0x000B=3042, 0x008A=3043; `done` follows.
- Grant toggling 1/0 each cycle during FILL w=4,h=1 → exactly 4 writes, consecutive addresses, no duplicates; `bus_req` held high throughout.
- CLEAR tile=0 → 16384 writes covering every address 0x0000-0x3FFF once; w=0 FILL → `done` without any `cs_ram`.
- Reset asserted after the 3rd write of a 6-write FILL → outputs at reset values the next cycle, no `done`, `cmd_ready`=1 after reset release.
